px_sample_uart_tx: RTL

- Consumer end of the pixel-scan bus controller's sample handshake.
- Takes one 32-bit sample per "data ready" event, tags it with a pixel index or a frame-start code, and serializes it to the host as a 5-byte 8N1 UART packet.
- Returns ack_received to the controller so the controller can advance to the next pixel.
- Sits between the scan controller and the board UART pin.

---
 rtl/px_sample_uart_tx.sv | 106 ++++++++++
 1 files changed

// File: rtl/px_sample_uart_tx.sv
// px_sample_uart_tx: latches a scan sample, sends it as a tagged 5-byte 8N1 UART packet, then acks with a 4-phase handshake
module px_sample_uart_tx #(
   parameter int          NUM_PX       = 24,
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [31:0] MARKER       = 32'h10101010,
   parameter logic [7:0]  MARKER_TAG   = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        drdy,
   input  logic [31:0] sampleOut,
   output logic        ack_received,
   output logic        tx,
   output logic        busy,
   output logic [4:0]  px_idx
);
   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, ACK, RELEASE} state_t;
   localparam logic [15:0] LAST    = 16'(CLKS_PER_BIT - 1);
   localparam logic [4:0]  PX_LAST = 5'(NUM_PX - 1);
   state_t      state_q, state_d;
   logic [31:0] s_q, s_d;
   logic [39:0] buf_q, buf_d;
   logic [4:0]  px_q, px_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d, byte_q, byte_d;
   logic        tx_q, tx_d, ack_q, ack_d, busy_q, busy_d;
   logic        bit_end, shifting;
   logic [7:0]  cur_byte;
   assign bit_end  = baud_q == LAST;
   assign shifting = state_q == START || state_q == DATA || state_q == STOP;
   assign cur_byte = buf_q[39:32];
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      buf_d   = buf_q;
      px_d    = px_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      baud_d  = (shifting && !bit_end) ? baud_q + 16'd1 : 16'd0;
      case (state_q)
         IDLE: if (!drdy) begin
            s_d     = sampleOut;
            state_d = LOAD;
         end
         LOAD: begin
            buf_d   = {(s_q == MARKER) ? MARKER_TAG : {3'b000, px_q}, s_q};
            px_d    = (s_q == MARKER || px_q == PX_LAST) ? 5'd0 : px_q + 5'd1;
            byte_d  = 3'd0;
            state_d = START;
         end
         START: if (bit_end) begin
            bit_d   = 3'd0;
            state_d = DATA;
         end
         DATA: if (bit_end) begin
            bit_d   = bit_q + 3'd1;
            state_d = (bit_q == 3'd7) ? STOP : DATA;
         end
         // stop exit doubles as the next-byte decision so bytes run back-to-back
         STOP: if (bit_end) begin
            if (byte_q < 3'd4) begin
               byte_d  = byte_q + 3'd1;
               buf_d   = {buf_q[31:0], 8'h00};
               state_d = START;
            end else begin
               state_d = ACK;
            end
         end
         ACK:     state_d = RELEASE;
         RELEASE: state_d = drdy ? IDLE : RELEASE;
         default: state_d = IDLE;
      endcase
      tx_d   = (state_q == START) ? 1'b0 : (state_q == DATA) ? cur_byte[bit_q] : 1'b1;
      ack_d  = state_q == ACK || (state_q == RELEASE && !drdy);
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         buf_q   <= '0;
         px_q    <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         tx_q    <= 1'b1;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         buf_q   <= buf_d;
         px_q    <= px_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         tx_q    <= tx_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end
   assign tx           = tx_q;
   assign ack_received = ack_q;
   assign busy         = busy_q;
   assign px_idx       = px_q;
endmodule
